// File: rtl/ad_ip_jesd204_tpl_adc_capture_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ad_ip_jesd204_tpl_adc_capture_ctrl: arm/resync/trigger/SOF capture gate   |
// | for the JESD204 TPL ADC path.                        Revision: 1.0        |
// +--------------------------------------------------------------------------+
module ad_ip_jesd204_tpl_adc_capture_ctrl #(
  parameter int NUM_CHANNELS    = 4,
  parameter int OCTETS_PER_BEAT = 4,
  parameter int LENGTH_WIDTH    = 32,
  parameter int SYNC_MIN_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       cfg_arm,
  input  logic                       cfg_abort,
  input  logic                       cfg_resync,
  input  logic [1:0]                 cfg_trig_mode,
  input  logic                       cfg_sw_trig,
  input  logic                       cfg_stop_on_ovf,
  input  logic [LENGTH_WIDTH-1:0]    cfg_length,
  input  logic                       trig_in,
  input  logic                       link_valid,
  input  logic [OCTETS_PER_BEAT-1:0] link_sof,
  input  logic [NUM_CHANNELS-1:0]    adc_valid_in,
  input  logic                       adc_dovf,
  input  logic                       adc_sync_status,
  output logic                       adc_sync,
  output logic [NUM_CHANNELS-1:0]    adc_valid_out,
  output logic                       capture_active,
  output logic                       status_busy,
  output logic                       status_done,
  output logic                       status_ovf,
  output logic [LENGTH_WIDTH-1:0]    status_beat_count,
  output logic [2:0]                 fsm_state
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SYNC     = 3'd1,
    ST_ARMED    = 3'd2,
    ST_WAIT_SOF = 3'd3,
    ST_CAPTURE  = 3'd4,
    ST_DONE     = 3'd5,
    ST_ERROR    = 3'd6
  } state_t;

  localparam int SYNC_CNT_W = $clog2(SYNC_MIN_CYCLES + 1);
  localparam logic [SYNC_CNT_W-1:0] SYNC_LAST = SYNC_CNT_W'(SYNC_MIN_CYCLES - 1);

  state_t                  state_q, state_d;
  logic [SYNC_CNT_W-1:0]   sync_cnt_q, sync_cnt_d;
  logic [LENGTH_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic                    done_q, done_d;
  logic                    ovf_q, ovf_d;
  logic                    trig_meta_q, trig_sync_q, trig_prev_q;

  logic                    gate_open;
  logic                    beat;
  logic                    length_hit;
  logic                    ovf_hit;
  logic                    trig_edge;
  logic                    arm_ok;
  logic [LENGTH_WIDTH-1:0] beat_cnt_inc;

  // Only the first octet's SOF marks a frame start on a beat boundary.
  generate
    if (OCTETS_PER_BEAT > 1) begin : g_sof_unused
      logic unused_sof_hi;
      assign unused_sof_hi = ^link_sof[OCTETS_PER_BEAT-1:1];
    end
  endgenerate

  // trig_in is asynchronous; the synchroniser runs in every state so an
  // edge seen while not ARMED simply goes nowhere.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      trig_meta_q <= 1'b0;
      trig_sync_q <= 1'b0;
      trig_prev_q <= 1'b0;
    end else begin
      trig_meta_q <= trig_in;
      trig_sync_q <= trig_meta_q;
      trig_prev_q <= trig_sync_q;
    end
  end

  assign trig_edge = trig_sync_q & ~trig_prev_q;

  // The gate is combinational so the first SOF beat passes with zero latency.
  assign gate_open    = (state_q == ST_CAPTURE) |
                        ((state_q == ST_WAIT_SOF) & link_valid & link_sof[0]);
  assign beat         = gate_open & (|adc_valid_in);
  assign beat_cnt_inc = beat_cnt_q + LENGTH_WIDTH'(1);
  assign length_hit   = beat & (cfg_length != '0) & (beat_cnt_inc == cfg_length);
  assign ovf_hit      = gate_open & adc_dovf;
  assign arm_ok       = (state_q == ST_IDLE) | (state_q == ST_DONE) |
                        (state_q == ST_ERROR);

  always_comb begin
    state_d    = state_q;
    sync_cnt_d = sync_cnt_q;
    beat_cnt_d = beat_cnt_q;
    done_d     = done_q;
    ovf_d      = ovf_q;

    if (cfg_abort) begin
      state_d    = ST_IDLE;
      beat_cnt_d = '0;
      done_d     = 1'b0;
      ovf_d      = 1'b0;
    end else if (cfg_arm && arm_ok) begin
      state_d    = cfg_resync ? ST_SYNC : ST_ARMED;
      sync_cnt_d = '0;
      beat_cnt_d = '0;
      done_d     = 1'b0;
      ovf_d      = 1'b0;
    end else begin
      unique case (state_q)
        ST_SYNC: begin
          if (sync_cnt_q != SYNC_LAST) begin
            sync_cnt_d = sync_cnt_q + SYNC_CNT_W'(1);
          end else if (!adc_sync_status) begin
            state_d = ST_ARMED;
          end
        end
        ST_ARMED: begin
          unique case (cfg_trig_mode)
            2'd1:    if (trig_edge)   state_d = ST_WAIT_SOF;
            2'd2:    if (cfg_sw_trig) state_d = ST_WAIT_SOF;
            default: state_d = ST_WAIT_SOF;
          endcase
        end
        ST_WAIT_SOF, ST_CAPTURE: begin
          if (gate_open) begin
            state_d = ST_CAPTURE;
          end
          if (beat) begin
            beat_cnt_d = beat_cnt_inc;
          end
          if (length_hit) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
          // An overflow stop outranks a coincident length completion.
          if (ovf_hit) begin
            ovf_d = 1'b1;
            if (cfg_stop_on_ovf) begin
              state_d = ST_ERROR;
            end
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      sync_cnt_q <= '0;
      beat_cnt_q <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_cnt_q <= sync_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
    end
  end

  assign adc_sync          = (state_q == ST_SYNC) & (sync_cnt_q == '0);
  assign adc_valid_out     = adc_valid_in & {NUM_CHANNELS{gate_open}};
  assign capture_active    = gate_open;
  assign status_busy       = ~arm_ok;
  assign status_done       = done_q;
  assign status_ovf        = ovf_q;
  assign status_beat_count = beat_cnt_q;
  assign fsm_state         = state_q;

endmodule
`default_nettype wire

// File: doc/ad_ip_jesd204_tpl_adc_capture_ctrl.md
Name: ad_ip_jesd204_tpl_adc_capture_ctrl

Overview:
- Capture sequencer for the JESD204 TPL ADC path, clocked by link_clk.
- Software arms it. It optionally requests a core resync, waits for a trigger, then aligns to a frame start (SOF).
- It then gates the per-channel core valid to the DMA for a programmed number of beats.
- It reports overflow, busy, done and beat count back to the regmap.

Parameters:
- NUM_CHANNELS, 4, number of converter channels (width of the valid gating).
- OCTETS_PER_BEAT, 4, width of link_sof.
- LENGTH_WIDTH, 32, width of the capture length and beat counter.
- SYNC_MIN_CYCLES, 4, minimum cycles spent in SYNC before adc_sync_status is checked (minimum 2).

Ports:
- clk  in  1  link clock; all logic is in this domain.
- resetn  in  1  asynchronous reset, active-low.
- cfg_arm  in  1  single-cycle arm request.
- cfg_abort  in  1  single-cycle abort; valid in any state.
- cfg_resync  in  1  when 1, the arm sequence passes through SYNC.
- cfg_trig_mode  in  2  trigger mode: 0 immediate, 1 trig_in rising edge, 2 software, 3 reserved (treated as 0).
- cfg_sw_trig  in  1  single-cycle software trigger.
- cfg_stop_on_ovf  in  1  when 1, adc_dovf during capture aborts into ERROR.
- cfg_length  in  LENGTH_WIDTH  number of beats to capture; 0 means continuous.
- trig_in  in  1  external trigger, asynchronous.
- link_valid  in  1  link data valid.
- link_sof  in  OCTETS_PER_BEAT  start-of-frame flags.
- adc_valid_in  in  NUM_CHANNELS  per-channel valid from the TPL core.
- adc_dovf  in  1  DMA overflow.
- adc_sync_status  in  1  core resync pending.
- adc_sync  out  1  one-cycle resync request to the core.
- adc_valid_out  out  NUM_CHANNELS  gated per-channel valid to the DMA.
- capture_active  out  1  gate is open.
- status_busy  out  1  state is not IDLE, DONE or ERROR.
- status_done  out  1  sticky; set when the length is reached.
- status_ovf  out  1  sticky; set on overflow.
- status_beat_count  out  LENGTH_WIDTH  beats captured in the current run.
- fsm_state  out  3  state encoding, for debug.

Behaviour:
- Reset values:
  - Every output is 0 and the state is IDLE.
  - The trig_in synchroniser flops and the beat counter clear.
- State encoding: IDLE=0, SYNC=1, ARMED=2, WAIT_SOF=3, CAPTURE=4, DONE=5, ERROR=6.
- Abort:
  - cfg_abort moves any state to IDLE on the next edge.
  - It clears status_done, status_ovf and the counter.
  - If it coincides with cfg_arm, abort wins.
- Arm:
  - cfg_arm is accepted only in IDLE, DONE or ERROR; it is ignored elsewhere.
  - Accepting it clears status_done, status_ovf and the counter.
  - Next state is SYNC if cfg_resync=1, else ARMED.
- SYNC:
  - adc_sync is 1 in the first cycle of SYNC only.
  - The state stays in SYNC for SYNC_MIN_CYCLES cycles, then until adc_sync_status==0, then moves to ARMED.
  - There is no timeout; software aborts if SYNC hangs.
- Trigger synchroniser:
  - trig_in passes through a 2-flop synchroniser plus an edge register, free-running in all states.
  - A rising edge is detected 3 clocks after trig_in rises.
  - Edges detected outside ARMED are discarded.
- ARMED transitions to WAIT_SOF on:
  - the next cycle, for mode 0 or 3;
  - a detected edge, for mode 1;
  - cfg_sw_trig, for mode 2.
- WAIT_SOF:
  - When link_valid & link_sof[0] in the same cycle, the gate opens combinationally in that cycle.
  - That beat is counted, and the state moves to CAPTURE.
- Gating:
  - adc_valid_out = adc_valid_in & {NUM_CHANNELS{open}}.
  - open = (state==CAPTURE) | (state==WAIT_SOF & link_valid & link_sof[0]).
  - capture_active = open. The gate adds zero latency.
- Counting:
  - A beat is any cycle with open and |adc_valid_in.
  - The counter increments per beat.
  - With cfg_length≠0: the beat on which count+1==cfg_length moves the state to DONE and sets status_done. No further beats pass; the gate is closed from the next cycle.
  - With cfg_length=1, a single beat at WAIT_SOF goes straight to DONE.
  - With cfg_length=0 the capture is continuous; the counter wraps modulo 2^LENGTH_WIDTH.
- Overflow:
  - adc_dovf while open sets status_ovf.
  - If cfg_stop_on_ovf=1, the state moves to ERROR on the next edge, and the beat in that cycle still passes.
  - adc_dovf outside the open gate is ignored.
- cfg_length is sampled continuously. Software must not change it while busy; if it does, the comparison uses the new value.
- DONE and ERROR hold their status until cfg_arm or cfg_abort.

Test Plan:
- Mode 0, no resync, cfg_length=8, continuous valid, SOF every 4 beats:
  - adc_valid_out passes exactly 8 beats starting at the first SOF.
  - status_done=1, count=8, fsm_state=5.
- Resync path, cfg_resync=1, adc_sync_status held high for 10 cycles:
  - adc_sync pulses for exactly 1 cycle.
  - ARMED is entered 1 cycle after status falls, and not before SYNC_MIN_CYCLES.
- Mode 1, trig_in pulse before arm then after arm:
  - The first pulse is ignored.
  - The second reaches WAIT_SOF 3 clocks after its rising edge.
- Overflow with cfg_stop_on_ovf=1, adc_dovf at beat 5 of 20:
  - status_ovf=1, state ERROR, 5 beats passed.
  - With cfg_stop_on_ovf=0, all 20 beats pass and status_ovf=1.
- Abort and arm asserted together during CAPTURE:
  - State is IDLE next cycle, gate closed, status cleared.
  - Asynchronous reset mid-capture zeroes all outputs immediately.
- cfg_length=0, LENGTH_WIDTH=4, 20 beats:
  - The counter wraps to 4, status_done stays 0, and the gate stays open until abort.
